// File: rtl/demux_1_2_stream_pkg.sv
// Shared definitions for the 1:2 stream demux (autoencoder defines).
// Holds the default word width and the routing FSM state encoding.
package demux_1_2_stream_pkg;

   localparam int DEF_DATA_WIDTH = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      ROUTE = 1'b1
   } state_t;

endpackage

// File: rtl/demux_1_2_stream_out_slot.sv
// out_slot: one-entry register slice feeding one demux output channel.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   load_i, data_i  write a new word into the slot (sets valid)
//   ready_i         consumer takes the held word this cycle
//   valid_o, data_o registered slot contents
// The upstream only loads when the slot is empty or draining, so a held
// word never changes while valid_o && !ready_i.
module out_slot #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  ready_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      // A load wins over a drain: the new word replaces the departing one.
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/demux_1_2_stream.sv
// demux_1_2_stream: routes one word stream to out_1 or out_2 in bursts
// of BURST_LEN words. The channel is picked from select when a burst
// starts (IDLE) and held for the whole burst.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_data/in_valid/in_ready   input stream
//   select                      channel for the next burst (0=out_1, 1=out_2)
//   out_x_data/valid/ready      registered output channels
//   busy                        high while routing a burst
//   burst_done                  one-cycle pulse after a burst's last accept
module demux_1_2_stream
   import demux_1_2_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BURST_LEN  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  select,
   output logic [DATA_WIDTH-1:0] out_1_data,
   output logic                  out_1_valid,
   input  logic                  out_1_ready,
   output logic [DATA_WIDTH-1:0] out_2_data,
   output logic                  out_2_valid,
   input  logic                  out_2_ready,
   output logic                  busy,
   output logic                  burst_done
);

   localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

   state_t     state_q, state_d;
   logic       sel_q, sel_d;
   logic [7:0] cnt_q, cnt_d;
   logic       done_q, done_d;
   logic       accept;

   logic [1:0]                 s_load, s_valid, s_ready;
   logic [1:0][DATA_WIDTH-1:0] s_data;

   assign s_ready = {out_2_ready, out_1_ready};

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      in_ready = 1'b0;
      accept   = 1'b0;
      s_load   = '0;
      case (state_q)
         IDLE: begin
            // Burst start costs one bubble cycle; select is only looked at here.
            if (in_valid) begin
               sel_d   = select;
               cnt_d   = '0;
               state_d = ROUTE;
            end
         end
         ROUTE: begin
            // Combinational pass-through of the selected consumer's ready.
            in_ready       = !s_valid[sel_q] || s_ready[sel_q];
            accept         = in_valid && in_ready;
            s_load[sel_q]  = accept;
            if (accept) begin
               if (cnt_q == LAST_CNT) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_slot
      out_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
         .clk     (clk),
         .rst_n   (rst_n),
         .load_i  (s_load[g]),
         .data_i  (in_data),
         .ready_i (s_ready[g]),
         .valid_o (s_valid[g]),
         .data_o  (s_data[g])
      );
   end

   assign out_1_data  = s_data[0];
   assign out_1_valid = s_valid[0];
   assign out_2_data  = s_data[1];
   assign out_2_valid = s_valid[1];
   assign busy        = (state_q == ROUTE);
   assign burst_done  = done_q;

endmodule

// File: doc/demux_1_2_stream.md
# demux_1_2_stream

Routes one 16-bit fixed-point word stream to one of two output channels in bursts of BURST_LEN words, with valid/ready handshakes on all sides. It sits between a single compute stage (e.g. the shared MAC/activation output) and two consumers (e.g. encoder-latent store vs. decoder input). It is the inverse of the team's 2:1 select mux. Each output has a one-entry register slot so that back-pressure on one channel never corrupts data.

## Interface
- DATA_WIDTH, 16, word width (Q-format fixed-point, routed unmodified)
- BURST_LEN, 4, words per burst; legal range 1..255
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low; one clock, synchronous active-low reset
- in_data  in  DATA_WIDTH  input word
- in_valid  in  1  input word present
- in_ready  out  1  block accepts in_data this cycle
- select  in  1  channel for next burst: 0 -> out_1, 1 -> out_2; sampled only in IDLE
- out_1_data / out_2_data  out  DATA_WIDTH  registered output words
- out_1_valid / out_2_valid  out  1  slot holds a word
- out_1_ready / out_2_ready  in  1  consumer takes the word
- busy  out  1  high while in ROUTE
- burst_done  out  1  one-cycle pulse on the cycle after the last word of a burst is accepted

## Operation
- The FSM has two states: IDLE and ROUTE.
- IDLE:
  - in_ready=0.
  - If in_valid=1: latch select into sel_q, clear the counter, go to ROUTE.
- ROUTE:
  - in_ready = !slot[sel_q].valid || out_sel_ready; this is a combinational pass-through path.
  - Accept = in_valid && in_ready. On accept: slot[sel_q] loads in_data, and its valid is set.
  - The counter increments on each accept.
  - On the accept that brings the count to BURST_LEN: go to IDLE, and pulse burst_done the next cycle.
- Each slot:
  - Valid clears when valid && ready and no load happens in the same cycle.
  - Data holds stable while valid && !ready.
  - The unselected slot continues draining a word left over from the previous burst; it never loads.
- A change on select during ROUTE is ignored.
- The block performs no arithmetic on data. The counter is 8 bits and is compared against BURST_LEN-1 at accept.

## Timing
- Reset values: in_ready=0, busy=0, burst_done=0, out_x_valid=0, out_x_data=0, counter=0, state=IDLE.
- Reset mid-burst discards slot contents and the count.
- The first word of every burst incurs a one-cycle bubble (the IDLE->ROUTE transition).
- Word latency: a word accepted at cycle t is on out_x_data with out_x_valid=1 at t+1.
- Throughput is 1 word/cycle while the selected out_x_ready stays high.
- Back-to-back bursts: min gap of 1 cycle between the last accept of one burst and the first accept of the next.
- BURST_LEN=1: each burst is IDLE, then one accept, then IDLE. burst_done follows every word.
- Simultaneous drain and load on the same slot: the new word replaces the old one. valid stays 1, and no word is lost or duplicated.

## Structure
- The shared package/header (autoencoder defines) holds:
  - DATA_WIDTH default
  - state encodings IDLE=1'b0, ROUTE=1'b1
- Sub-module out_slot is a one-entry register slice with load/drain/valid, instantiated twice.
- The FSM and counter live in the top.

## Test plan
- Burst to out_1, no back-pressure: BURST_LEN=4, select=0, words 0x0001..0x0004 with in_valid held → out_1 shows 0x0001..0x0004 on consecutive cycles; out_2_valid stays 0; burst_done pulses once.
- Alternating bursts: select=0 then 1, words 0x1000..0x1007 → 0x1000..0x1003 appear on out_1 and 0x1004..0x1007 on out_2, with a one-cycle gap between bursts.
- Back-pressure: out_2_ready=0 for 3 cycles mid-burst → out_2_data holds 0xBEEF stable; in_ready=0; after ready rises, the remaining words arrive in order with no loss.
- Select toggled mid-burst: select flips 0→1 during ROUTE → all BURST_LEN words still go to out_1.
- Reset mid-burst: rst_n=0 after 2 of 4 words → next cycle, all outputs are at reset values; a new burst starts cleanly from count 0.
- BURST_LEN=1 stream of 0xA5A5, 0x5A5A, select=1 → both words appear on out_2; burst_done pulses twice.
